// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {IDLE, HDR, DATA, WR, RUN, ERR} loader_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs an MSB-first byte stream into instruction words and flags the last byte of each word.
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_W = 8 * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    input  logic              clear,
    output logic [DATA_W-1:0] word_out,
    output logic              last_byte
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            word_d     = '0;
            byte_cnt_d = '0;
        end else if (shift_en) begin
            word_d     = {word_q[DATA_W-9:0], byte_in};
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Post-shift view, so the word is complete in the same cycle its last byte arrives.
    assign word_out  = word_d;
    assign last_byte = (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: streams a length-prefixed byte program into instruction memory
// and holds the processor in clear until the last word is written.
//
// state | meaning
// IDLE  | out of reset, waiting for start; cpu held in clear
// HDR   | waiting for the word-count byte
// DATA  | shifting program bytes into the assembler
// WR    | single-cycle write of the assembled word
// RUN   | program loaded, cpu released
// ERR   | header was zero or too large; cpu held in clear
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_data,
    output logic              cpu_clr,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = $clog2(MAX_WORDS);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_wen_q, imem_wen_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_data_q, imem_data_d;
    logic              cpu_clr_q, cpu_clr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic              asm_clear;
    logic              asm_shift;
    logic              asm_last;
    logic [DATA_W-1:0] asm_word;

    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk       (clk),
        .clr_n     (clr_n),
        .shift_en  (asm_shift),
        .byte_in   (in_byte),
        .clear     (asm_clear),
        .word_out  (asm_word),
        .last_byte (asm_last)
    );

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;

        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                if (xfer) begin
                    if (in_byte == 8'd0 || int'(in_byte) > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        // Keep N-1 so the end test fits word_idx width even at N == MAX_WORDS.
                        last_idx_d = IDX_W'(in_byte - 8'd1);
                        word_idx_d = '0;
                        asm_clear  = 1'b1;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    asm_shift = 1'b1;
                    if (asm_last) state_d = WR;
                end
            end
            WR: begin
                if (word_idx_q == last_idx_q) begin
                    state_d = RUN;
                end else begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    state_d    = DATA;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == HDR) || (state_d == DATA);
        imem_wen_d  = (state_d == WR);
        cpu_clr_d   = (state_d != RUN);
        done_d      = (state_d == RUN);
        error_d     = (state_d == ERR);
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        if (state_d == WR) begin
            imem_addr_d = ADDR_W'({word_idx_q, 2'b00});
            imem_data_d = asm_word;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            word_idx_q  <= '0;
            last_idx_q  <= '0;
            in_ready_q  <= 1'b0;
            imem_wen_q  <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cpu_clr_q   <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            last_idx_q  <= last_idx_d;
            in_ready_q  <= in_ready_d;
            imem_wen_q  <= imem_wen_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cpu_clr_q   <= cpu_clr_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign imem_wen  = imem_wen_q;
    assign imem_addr = imem_addr_q;
    assign imem_data = imem_data_q;
    assign cpu_clr   = cpu_clr_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, illegal header, backpressure, reset, reload and max-size loads.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        imem_wen;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        cpu_clr;
    logic        done;
    logic        error;

    program_loader #(.ADDR_W(8), .DATA_W(32), .MAX_WORDS(64)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .imem_wen  (imem_wen),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .cpu_clr   (cpu_clr),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int t0;
    int bad;

    logic [7:0]  stream[$];
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Record every write cycle a little after the edge that launched it.
    always begin
        @(posedge clk);
        #2;
        if (imem_wen === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({in_ready, imem_wen, cpu_clr, done, error});
    endfunction

    task automatic wr_clear();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_wr(input string tag, input int i, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] oa;
        logic [31:0] od;
        oa = (i < wr_addr_q.size()) ? 32'(wr_addr_q[i]) : 32'hxxxx_xxxx;
        od = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx;
        check({tag, "_addr"}, oa, 32'(a));
        check({tag, "_data"}, od, d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds the stream; stalls randomly, but holds in_valid high whenever the loader is not ready.
    task automatic run_stream(input int stall_pct, input int start_at);
        int idx = 0;
        int guard = 0;
        while (idx < stream.size() && guard < 5000) begin
            in_valid = (stall_pct == 0) || (int'($urandom_range(99)) >= stall_pct) || !in_ready;
            in_byte  = in_valid ? stream[idx] : 8'hEE;
            start    = (idx == start_at);
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        in_byte  = 8'h00;
        start    = 1'b0;
        check("stream_consumed", 32'(idx), 32'(stream.size()));
    endtask

    task automatic wait_done();
        int g = 0;
        while (done !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        clr_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_flags", flags(), 32'b00100);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_data", imem_data, 32'h0);
        clr_n = 1'b1;

        // Valid bytes offered while idle must be ignored.
        in_valid = 1'b1;
        in_byte  = 8'h01;
        repeat (3) @(negedge clk);
        check("idle_flags", flags(), 32'b00100);
        in_valid = 1'b0;

        // Nominal 3-word load with in_valid held high.
        wr_clear();
        t0 = edge_cnt;
        pulse_start();
        check("start_ready", 32'(in_ready), 32'd1);
        stream = {8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20,
                  8'h10, 8'h00, 8'hFF, 8'hFF};
        run_stream(0, -1);
        check("load_clr_held", 32'({cpu_clr, done}), 32'b10);
        wait_done();
        check("release_latency", 32'(edge_cnt - t0), 32'd17);
        check("release_clr", 32'(cpu_clr), 32'd0);
        check("nom_count", 32'(wr_addr_q.size()), 32'd3);
        check_wr("nom_w0", 0, 8'h00, 32'h2008_0005);
        check_wr("nom_w1", 1, 8'h04, 32'h0109_5020);
        check_wr("nom_w2", 2, 8'h08, 32'h1000_FFFF);

        // Restart from RUN, with a start pulse mid-DATA that must be ignored.
        wr_clear();
        pulse_start();
        check("reload_flags", 32'({in_ready, cpu_clr, done}), 32'b110);
        stream = {8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        run_stream(0, 3);
        wait_done();
        check("reload_count", 32'(wr_addr_q.size()), 32'd2);
        check_wr("reload_w0", 0, 8'h00, 32'hDEAD_BEEF);
        check_wr("reload_w1", 1, 8'h04, 32'h1234_5678);

        // Illegal headers: zero, then one above the maximum.
        wr_clear();
        pulse_start();
        stream = {8'h00};
        run_stream(0, -1);
        check("hdr0_flags", flags(), 32'b00101);
        pulse_start();
        check("hdr0_restart", 32'({in_ready, error}), 32'b10);
        stream = {8'h41};
        run_stream(0, -1);
        check("hdr65_flags", flags(), 32'b00101);
        check("err_no_write", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();
        check("hdr65_restart", 32'({in_ready, error}), 32'b10);

        // Backpressure: random stalls, valid held high through WR.
        wr_clear();
        stream = {8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20,
                  8'h10, 8'h00, 8'hFF, 8'hFF};
        run_stream(40, -1);
        wait_done();
        check("bp_count", 32'(wr_addr_q.size()), 32'd3);
        check_wr("bp_w0", 0, 8'h00, 32'h2008_0005);
        check_wr("bp_w1", 1, 8'h04, 32'h0109_5020);
        check_wr("bp_w2", 2, 8'h08, 32'h1000_FFFF);

        // Reset after 6 data bytes: outputs clear at once, only word 0 was written.
        wr_clear();
        pulse_start();
        stream = {8'h03, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09};
        run_stream(0, -1);
        clr_n = 1'b0;
        #1;
        check("midrst_flags", flags(), 32'b00100);
        check("midrst_addr", 32'(imem_addr), 32'h0);
        check("midrst_data", imem_data, 32'h0);
        check("midrst_count", 32'(wr_addr_q.size()), 32'd1);
        check_wr("midrst_w0", 0, 8'h00, 32'h2008_0005);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        wr_clear();
        pulse_start();
        stream = {8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run_stream(0, -1);
        wait_done();
        check("post_rst_count", 32'(wr_addr_q.size()), 32'd1);
        check_wr("post_rst_w0", 0, 8'h00, 32'hCAFE_BABE);

        // Maximum-size program: 64 words, last address 0xFC.
        wr_clear();
        pulse_start();
        stream = {8'h40};
        for (int i = 0; i < 64; i++) begin
            stream.push_back(8'(i));
            stream.push_back(~8'(i));
            stream.push_back(8'h5A);
            stream.push_back(8'(i + 3));
        end
        run_stream(0, -1);
        wait_done();
        check("max_count", 32'(wr_addr_q.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (i >= wr_addr_q.size()) bad++;
            else if (wr_addr_q[i] !== 8'(i * 4) ||
                     wr_data_q[i] !== {8'(i), ~8'(i), 8'h5A, 8'(i + 3)}) bad++;
        end
        check("max_all_words", 32'(bad), 32'd0);
        check_wr("max_last", 63, 8'hFC, {8'd63, ~8'd63, 8'h5A, 8'd66});
        repeat (2) @(negedge clk);
        check("max_addr_hold", 32'(imem_addr), 32'hFC);
        check("max_run_flags", flags(), 32'b00010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
